uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter: the transmit end of the serial link whose receive end shifts bits in LSB-first.
- Accepts one W_IN-bit word over a valid/ready handshake.
- Splits the word into NUM_WORDS = W_IN/BITS_PER_WORD characters.
- Serialises each character as start bit, data bits LSB-first, then stop bit(s).
- Character 0 is bits [BITS_PER_WORD-1:0] and goes first, so a matching receiver reassembles the original word unchanged.

Parameters:
- CLOCKS_PER_PULSE, 4, clk cycles per serial bit period; must be >= 2.
- BITS_PER_WORD, 8, data bits per character.
- W_IN, 16, width of the parallel input word; must be an integer multiple of BITS_PER_WORD.
- STOP_BITS, 1, stop-bit periods per character; must be >= 1.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- s_valid  input  1  upstream word valid
- s_ready  output  1  block can accept a word; high exactly when state == IDLE
- s_data  input  W_IN  word to transmit; sampled only on accept
- tx  output  1  serial line, idle high; driven from a register, no combinational path from inputs

Behaviour:
- Reset values (asynchronous): state=IDLE, tx=1, s_ready=1, all counters 0, shift register 0.
- Reset mid-frame: tx returns to 1 immediately and the partial frame is abandoned; no resume after reset release.
- Accept: occurs on the rising edge where s_valid && s_ready.
  - s_data is loaded into the internal shift register.
  - state goes to START; tx=0 and s_ready=0 from the following cycle.
- s_valid and s_data are ignored while s_ready=0. Holding s_valid high through a frame does not queue a second word.
- State machine:
  - IDLE: tx=1. On accept go to START.
  - START: tx=0 for CLOCKS_PER_PULSE cycles, then go to DATA.
  - DATA: tx = shift register bit 0, held for CLOCKS_PER_PULSE cycles. At the end of each bit period the register shifts right by 1. After BITS_PER_WORD bits go to END.
  - END: tx=1 for STOP_BITS*CLOCKS_PER_PULSE cycles. If the character counter < NUM_WORDS-1, increment it and go to START (no idle gap between characters). Otherwise clear it and go to IDLE.
- Counters:
  - clock counter: ceil(log2(STOP_BITS*CLOCKS_PER_PULSE)) bits.
  - bit counter: sized for BITS_PER_WORD.
  - character counter: sized for NUM_WORDS, minimum 1 bit so NUM_WORDS=1 is legal.
  - All counters wrap to 0 exactly at their terminal value, never beyond.
- Frame timing: s_ready stays low for exactly NUM_WORDS*(1+BITS_PER_WORD+STOP_BITS)*CLOCKS_PER_PULSE cycles after the accept edge.
  - It is high again in the cycle following the last stop-bit cycle.
  - Back-to-back words are separated by at least one IDLE cycle (tx=1). Minimum word-to-word period is frame length + 1 cycle.
- Every bit period is exactly CLOCKS_PER_PULSE cycles, with no jitter. A receiver that samples mid-bit therefore always sees stable data.

Test Plan:
- Defaults, send s_data=0xA55A -> tx = 0, 0,1,0,1,1,0,1,0, 1, then 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles. s_ready low for exactly 80 cycles, then high.
- Loopback into the receiver (same defaults), words 0x0000, 0xFFFF, 0x1234, 0x8001 -> receiver outputs each word once, m_valid pulses once per word, data identical.
- s_valid held high continuously with 0x00FF then 0xFF00 -> two frames, each accepted only in IDLE. Exactly one tx=1 idle cycle between frame 1's final stop bit and frame 2's start bit.
- s_valid pulsed, with s_data changed, during the DATA state of an active frame -> tx sequence unchanged, no extra accept, s_ready stays 0.
- rstn asserted in the 3rd data bit of character 1 -> tx=1 and s_ready=1 during reset. After release, a new accept of 0x00C3 transmits a clean full frame.
- STOP_BITS=2, W_IN=8, CLOCKS_PER_PULSE=3, send 0x81 -> start 3 cycles low, bits 1,0,0,0,0,0,0,1 at 3 cycles each, stop high 6 cycles. s_ready low 33 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: takes one W_IN-bit word per handshake and sends it as NUM_WORDS characters,
// character 0 first, each framed as start bit, LSB-first data bits, then stop bit(s).
module uart_tx #(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned W_IN             = 16,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W_IN-1:0] s_data,
  output logic            tx
);

  localparam int unsigned NumWords  = W_IN / BITS_PER_WORD;
  localparam int unsigned StopClks  = STOP_BITS * CLOCKS_PER_PULSE;
  localparam int unsigned ClkW      = $clog2(StopClks);
  localparam int unsigned BitW      = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int unsigned CharW     = (NumWords > 1) ? $clog2(NumWords) : 1;

  localparam logic [ClkW-1:0]  PulseLast = ClkW'(CLOCKS_PER_PULSE - 1);
  localparam logic [ClkW-1:0]  StopLast  = ClkW'(StopClks - 1);
  localparam logic [BitW-1:0]  BitLast   = BitW'(BITS_PER_WORD - 1);
  localparam logic [CharW-1:0] CharLast  = CharW'(NumWords - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StEnd} state_e;

  state_e            state_q, state_d;
  logic [ClkW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CharW-1:0]  char_cnt_q, char_cnt_d;
  logic [W_IN-1:0]   shift_q, shift_d;
  logic              tx_q, tx_d;

  assign s_ready = (state_q == StIdle);
  assign tx      = tx_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      char_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      char_cnt_q <= char_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    char_cnt_d = char_cnt_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          shift_d   = s_data;
          clk_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (clk_cnt_q == PulseLast) begin
          clk_cnt_d = '0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (clk_cnt_q == PulseLast) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = StEnd;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StEnd: begin
        if (clk_cnt_q == StopLast) begin
          clk_cnt_d = '0;
          if (char_cnt_q < CharLast) begin
            char_cnt_d = char_cnt_q + 1'b1;
            state_d    = StStart;
          end else begin
            char_cnt_d = '0;
            state_d    = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Line level is registered from the next state so tx has no path from the inputs.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default instance plus a (CPP=3, W_IN=8, STOP_BITS=2) instance, checked
// against an expected line waveform and a mid-bit sampling receiver.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid_a, s_valid_b;
  logic        s_ready_a, s_ready_b;
  logic [15:0] s_data_a;
  logic [7:0]  s_data_b;
  logic        tx_a, tx_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx u_dut_a (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid_a),
    .s_ready (s_ready_a),
    .s_data  (s_data_a),
    .tx      (tx_a)
  );

  uart_tx #(
    .CLOCKS_PER_PULSE (3),
    .BITS_PER_WORD    (8),
    .W_IN             (8),
    .STOP_BITS        (2)
  ) u_dut_b (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid_b),
    .s_ready (s_ready_b),
    .s_data  (s_data_b),
    .tx      (tx_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic cur_ready(input bit sel);
    return sel ? s_ready_b : s_ready_a;
  endfunction

  // Called at a negedge with s_valid/s_data already driven; returns at the first idle negedge.
  task automatic run_frame(input bit sel, input logic [15:0] w, input int cpp, input int nbits,
                           input int nw, input int stop, input bit poke, output int waited);
    bit          exp_q[$];
    logic        trace[$];
    logic [15:0] got;
    int          flen;
    for (int c = 0; c < nw; c++) begin
      for (int k = 0; k < cpp; k++) exp_q.push_back(1'b0);
      for (int b = 0; b < nbits; b++)
        for (int k = 0; k < cpp; k++) exp_q.push_back(w[c*nbits+b]);
      for (int k = 0; k < stop * cpp; k++) exp_q.push_back(1'b1);
    end
    flen   = exp_q.size();
    waited = 0;
    while (cur_ready(sel) !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", cur_ready(sel), 1'b1);
    check("idle_tx", cur_tx(sel), 1'b1);
    for (int i = 0; i < flen; i++) begin
      @(negedge clk);
      if (poke) begin
        if (i >= 8 && i < 30) begin
          s_valid_a = (i % 3 == 0);
          s_data_a  = 16'($urandom);
        end else if (i >= 30) begin
          s_valid_a = 1'b0;
        end
      end
      check("tx_level", cur_tx(sel), exp_q[i]);
      check("ready_busy", cur_ready(sel), 1'b0);
      trace.push_back(cur_tx(sel));
    end
    @(negedge clk);
    check("ready_after", cur_ready(sel), 1'b1);
    check("idle_after", cur_tx(sel), 1'b1);
    got = '0;
    for (int c = 0; c < nw; c++)
      for (int b = 0; b < nbits; b++)
        got[c*nbits+b] = trace[(c*(1+nbits+stop) + 1 + b) * cpp + cpp/2];
    check("loopback", got, w);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] words [4];
    int          waited;
    words = '{16'h0000, 16'hFFFF, 16'h1234, 16'h8001};

    rstn = 1'b0; s_valid_a = 1'b0; s_valid_b = 1'b0; s_data_a = '0; s_data_b = '0;
    repeat (2) @(negedge clk);
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_ready_a", s_ready_a, 1'b1);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_ready_b", s_ready_b, 1'b1);
    rstn = 1'b1;
    @(negedge clk);

    s_data_a = 16'hA55A; s_valid_a = 1'b1;
    run_frame(1'b0, 16'hA55A, 4, 8, 2, 1, 1'b0, waited);
    s_valid_a = 1'b0;

    foreach (words[i]) begin
      @(negedge clk);
      s_data_a = words[i]; s_valid_a = 1'b1;
      run_frame(1'b0, words[i], 4, 8, 2, 1, 1'b0, waited);
      s_valid_a = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      w = 16'($urandom);
      s_data_a = w; s_valid_a = 1'b1;
      run_frame(1'b0, w, 4, 8, 2, 1, 1'b0, waited);
      s_valid_a = 1'b0;
    end

    // s_valid held across two frames: second accept must follow one idle cycle.
    @(negedge clk);
    s_data_a = 16'h00FF; s_valid_a = 1'b1;
    run_frame(1'b0, 16'h00FF, 4, 8, 2, 1, 1'b0, waited);
    s_data_a = 16'hFF00;
    run_frame(1'b0, 16'hFF00, 4, 8, 2, 1, 1'b0, waited);
    check("one_idle_gap", waited, 0);
    s_valid_a = 1'b0;

    @(negedge clk);
    w = 16'($urandom);
    s_data_a = w; s_valid_a = 1'b1;
    run_frame(1'b0, w, 4, 8, 2, 1, 1'b1, waited);
    s_valid_a = 1'b0;

    // Reset during the third data bit of character 1 (cycles 52..55 after accept).
    @(negedge clk);
    w = 16'($urandom);
    s_data_a = w; s_valid_a = 1'b1;
    check("pre_accept_ready", s_ready_a, 1'b1);
    @(negedge clk);
    s_valid_a = 1'b0;
    repeat (53) @(negedge clk);
    check("pre_reset_bit", tx_a, w[10]);
    check("pre_reset_busy", s_ready_a, 1'b0);
    #1 rstn = 1'b0;
    #1;
    check("in_reset_tx", tx_a, 1'b1);
    check("in_reset_ready", s_ready_a, 1'b1);
    repeat (2) @(negedge clk);
    check("hold_reset_tx", tx_a, 1'b1);
    check("hold_reset_ready", s_ready_a, 1'b1);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_tx", tx_a, 1'b1);
    check("post_reset_ready", s_ready_a, 1'b1);
    s_data_a = 16'h00C3; s_valid_a = 1'b1;
    run_frame(1'b0, 16'h00C3, 4, 8, 2, 1, 1'b0, waited);
    s_valid_a = 1'b0;

    @(negedge clk);
    s_data_b = 8'h81; s_valid_b = 1'b1;
    run_frame(1'b1, 16'h0081, 3, 8, 1, 2, 1'b0, waited);
    s_valid_b = 1'b0;
    repeat (2) begin
      @(negedge clk);
      w = {8'h00, 8'($urandom)};
      s_data_b = w[7:0]; s_valid_b = 1'b1;
      run_frame(1'b1, w, 3, 8, 1, 2, 1'b0, waited);
      s_valid_b = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
